// File: rtl/wb_stream_writer_pkg.sv
// Shared types for the stream-to-Wishbone writer: FSM states and decoded device responses.
package wb_stream_writer_pkg;

    typedef enum logic [1:0] {IDLE, REQ, BACKOFF} state_t;

    typedef enum logic [1:0] {RESP_NONE, RESP_ACK, RESP_RTY, RESP_ERR} resp_t;

    // err wins over rty, rty wins over ack when a device raises several at once
    function automatic resp_t decode_resp(input logic ack, input logic err, input logic rty);
        if (err) begin
            return RESP_ERR;
        end else if (rty) begin
            return RESP_RTY;
        end else if (ack) begin
            return RESP_ACK;
        end
        return RESP_NONE;
    endfunction

endpackage

// File: rtl/wb_stream_writer_fifo_sync.sv
// Synchronous FIFO with combinational head and second-entry outputs.
module fifo_sync #(
    parameter int unsigned DAT_WIDTH = 8,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DAT_WIDTH-1:0]       din,
    output logic [DAT_WIDTH-1:0]       dout,
    output logic [DAT_WIDTH-1:0]       dout_next,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DAT_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr_q;
    logic [AW:0]          rd_ptr_q;
    logic [AW-1:0]        rd_idx_next;
    logic                 do_push;
    logic                 do_pop;

    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign count       = wr_ptr_q - rd_ptr_q;
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_idx_next = rd_ptr_q[AW-1:0] + AW'(1);
    assign dout        = mem[rd_ptr_q[AW-1:0]];
    // Only meaningful while count >= 2; lets the writer preload the next word on ack
    assign dout_next   = mem[rd_idx_next];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/wb_stream_writer.sv
// Wishbone classic write controller draining a buffered valid/ready stream, with bounded retry.
module wb_stream_writer
    import wb_stream_writer_pkg::*;
#(
    parameter int unsigned DAT_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [DAT_WIDTH-1:0] s_data_i,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [DAT_WIDTH-1:0] dat_o,
    input  logic                 ack_i,
    input  logic                 err_i,
    input  logic                 rty_i,
    output logic                 drop_o,
    output logic                 busy_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] MaxRetry = RW'(MAX_RETRY);

    state_t               state_q, state_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;
    logic                 drop_q, drop_d;
    logic                 s_ready_q, s_ready_d;
    resp_t                resp;

    logic                 push;
    logic                 pop;
    logic [DAT_WIDTH-1:0] head;
    logic [DAT_WIDTH-1:0] head_next;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;

    assign push = s_valid_i && s_ready_q;

    fifo_sync #(
        .DAT_WIDTH(DAT_WIDTH),
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (push),
        .pop      (pop),
        .din      (s_data_i),
        .dout     (head),
        .dout_next(head_next),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign cyc_o     = (state_q == REQ);
    assign stb_o     = cyc_o;
    assign we_o      = cyc_o;
    assign dat_o     = dat_q;
    assign drop_o    = drop_q;
    assign s_ready_o = s_ready_q;
    assign busy_o    = !empty || cyc_o;

    // Responses outside a cycle are ignored
    assign resp = cyc_o ? decode_resp(ack_i, err_i, rty_i) : RESP_NONE;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        dat_d   = dat_q;
        drop_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = REQ;
                    dat_d   = head;
                end
            end
            REQ: begin
                unique case (resp)
                    RESP_ACK: begin
                        pop     = 1'b1;
                        retry_d = '0;
                        if (count >= CW'(2)) begin
                            dat_d = head_next;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    RESP_ERR: begin
                        pop     = 1'b1;
                        drop_d  = 1'b1;
                        retry_d = '0;
                        state_d = IDLE;
                    end
                    RESP_RTY: begin
                        if (retry_q == MaxRetry) begin
                            pop     = 1'b1;
                            drop_d  = 1'b1;
                            retry_d = '0;
                            state_d = IDLE;
                        end else begin
                            retry_d = retry_q + RW'(1);
                            state_d = BACKOFF;
                        end
                    end
                    default: ;
                endcase
            end
            BACKOFF: begin
                state_d = REQ;
                dat_d   = head;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready tracks the post-edge occupancy, so a same-cycle pop cannot open it early
    always_comb begin
        s_ready_d = !full;
        unique case ({push, pop})
            2'b10:   s_ready_d = (count != CW'(FIFO_DEPTH - 1));
            2'b01:   s_ready_d = 1'b1;
            default: s_ready_d = !full;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            retry_q   <= '0;
            dat_q     <= '0;
            drop_q    <= 1'b0;
            s_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            retry_q   <= retry_d;
            dat_q     <= dat_d;
            drop_q    <= drop_d;
            s_ready_q <= s_ready_d;
        end
    end

endmodule
